rf_write_scheduler: RTL and testbench

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

---
 rtl/rf_write_scheduler_if.sv | 40 ++++
 rtl/rf_write_scheduler.sv | 102 ++++++++++
 tb/tb_rf_write_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_scheduler_if.sv
// Register-file write scheduler bus: two write requesters, clear control,
// and the register-file write port.
interface rf_write_scheduler_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
);
  logic                 clear_req_i;
  logic                 clear_busy_o;
  logic                 clear_done_o;
  logic                 rq0_valid_i;
  logic [AddrWidth-1:0] rq0_addr_i;
  logic [DataWidth-1:0] rq0_data_i;
  logic                 rq0_ready_o;
  logic                 rq1_valid_i;
  logic [AddrWidth-1:0] rq1_addr_i;
  logic [DataWidth-1:0] rq1_data_i;
  logic                 rq1_ready_o;
  logic                 rf_we_o;
  logic [AddrWidth-1:0] rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 x0_drop_o;

  modport master (
    output clear_req_i,
    output rq0_valid_i, rq0_addr_i, rq0_data_i,
    output rq1_valid_i, rq1_addr_i, rq1_data_i,
    input  clear_busy_o, clear_done_o,
    input  rq0_ready_o, rq1_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, x0_drop_o
  );

  modport slave (
    input  clear_req_i,
    input  rq0_valid_i, rq0_addr_i, rq0_data_i,
    input  rq1_valid_i, rq1_addr_i, rq1_data_i,
    output clear_busy_o, clear_done_o,
    output rq0_ready_o, rq1_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, x0_drop_o
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Round-robin register-file write scheduler with a bulk clear sequence
// that zeroes registers 1..NumRegs-1 while stalling both requesters.
module rf_write_scheduler #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rf_write_scheduler_if.slave  bus
);

  localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] LastAddr  = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q;
  logic                 last_gnt_q;
  logic                 we_q;
  logic [AddrWidth-1:0] waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 done_q;
  logic                 drop_q;

  logic                 idle;
  logic                 gnt0;
  logic                 gnt1;
  logic                 hs;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 clear_last;

  assign idle       = (state_q == IDLE) && rst_ni;
  assign clear_last = (state_q == CLEAR) && (cnt_q == LastAddr);

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_d  = state_q;
    sel_addr = bus.rq0_addr_i;
    sel_data = bus.rq0_data_i;
    if (idle) begin
      // last_gnt_q=1 means requester 1 won last, so requester 0 wins ties
      gnt0 = bus.rq0_valid_i & (~bus.rq1_valid_i | last_gnt_q);
      gnt1 = bus.rq1_valid_i & (~bus.rq0_valid_i | ~last_gnt_q);
    end
    if (gnt1) begin
      sel_addr = bus.rq1_addr_i;
      sel_data = bus.rq1_data_i;
    end
    unique case (state_q)
      IDLE:  if (bus.clear_req_i) state_d = CLEAR;
      CLEAR: if (clear_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hs = gnt0 | gnt1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= FirstAddr;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= clear_last;
      drop_q  <= hs && (sel_addr == '0);
      we_q    <= 1'b0;
      if (hs) last_gnt_q <= gnt1;
      if (state_q == CLEAR) begin
        we_q    <= 1'b1;
        waddr_q <= cnt_q;
        wdata_q <= '0;
        cnt_q   <= clear_last ? FirstAddr : cnt_q + FirstAddr;
      end else begin
        cnt_q <= FirstAddr;
        if (hs && (sel_addr != '0)) begin
          we_q    <= 1'b1;
          waddr_q <= sel_addr;
          wdata_q <= sel_data;
        end
      end
    end
  end

  assign bus.rq0_ready_o  = gnt0;
  assign bus.rq1_ready_o  = gnt1;
  assign bus.clear_busy_o = (state_q == CLEAR);
  assign bus.clear_done_o = done_q;
  assign bus.rf_we_o      = we_q;
  assign bus.rf_waddr_o   = waddr_q;
  assign bus.rf_wdata_o   = wdata_q;
  assign bus.x0_drop_o    = drop_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: arbitration, x0 drop,
// clear sequence, reset abort and clear re-trigger.
module tb_rf_write_scheduler;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   nwr;
  int   ndone;
  int   lastw;

  always #5 clk = ~clk;

  rf_write_scheduler_if #(.DataWidth(32), .AddrWidth(5)) bus ();

  rf_write_scheduler #(.DataWidth(32), .AddrWidth(5)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.clear_req_i = 1'b0;
    bus.rq0_valid_i = 1'b0;
    bus.rq0_addr_i  = '0;
    bus.rq0_data_i  = '0;
    bus.rq1_valid_i = 1'b0;
    bus.rq1_addr_i  = '0;
    bus.rq1_data_i  = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_in();
    bus.rq0_valid_i = 1'b1;
    rst_ni = 1'b0;
    tick();
    tick();
    chk("rst_ready0", 32'(bus.rq0_ready_o), 0);
    chk("rst_we", 32'(bus.rf_we_o), 0);
    chk("rst_waddr", 32'(bus.rf_waddr_o), 0);
    chk("rst_wdata", bus.rf_wdata_o, 0);
    chk("rst_busy", 32'(bus.clear_busy_o), 0);
    chk("rst_done", 32'(bus.clear_done_o), 0);
    chk("rst_drop", 32'(bus.x0_drop_o), 0);
    bus.rq0_valid_i = 1'b0;
    rst_ni = 1'b1;

    // single request
    bus.rq0_valid_i = 1'b1;
    bus.rq0_addr_i  = 5'd5;
    bus.rq0_data_i  = 32'hDEADBEEF;
    #1;
    chk("single_ready0", 32'(bus.rq0_ready_o), 1);
    chk("single_ready1", 32'(bus.rq1_ready_o), 0);
    tick();
    bus.rq0_valid_i = 1'b0;
    chk("single_we", 32'(bus.rf_we_o), 1);
    chk("single_waddr", 32'(bus.rf_waddr_o), 5);
    chk("single_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
    tick();
    chk("idle_we", 32'(bus.rf_we_o), 0);
    chk("hold_waddr", 32'(bus.rf_waddr_o), 5);
    chk("hold_wdata", bus.rf_wdata_o, 32'hDEADBEEF);

    // contention right after reset
    do_reset();
    bus.rq0_valid_i = 1'b1;
    bus.rq0_addr_i  = 5'd1;
    bus.rq0_data_i  = 32'h11;
    bus.rq1_valid_i = 1'b1;
    bus.rq1_addr_i  = 5'd2;
    bus.rq1_data_i  = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", 32'(bus.rq0_ready_o), (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", 32'(bus.rq1_ready_o), (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_we", 32'(bus.rf_we_o), 1);
      chk("rr_waddr", 32'(bus.rf_waddr_o), (i % 2 == 0) ? 1 : 2);
      chk("rr_wdata", bus.rf_wdata_o, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    idle_in();

    // write to x0
    bus.rq1_valid_i = 1'b1;
    bus.rq1_addr_i  = 5'd0;
    bus.rq1_data_i  = 32'h1234;
    #1;
    chk("x0_ready1", 32'(bus.rq1_ready_o), 1);
    tick();
    idle_in();
    chk("x0_we", 32'(bus.rf_we_o), 0);
    chk("x0_drop", 32'(bus.x0_drop_o), 1);
    tick();
    chk("x0_drop_end", 32'(bus.x0_drop_o), 0);

    // clear with rq0 pending
    bus.clear_req_i = 1'b1;
    bus.rq0_valid_i = 1'b1;
    bus.rq0_addr_i  = 5'd3;
    bus.rq0_data_i  = 32'h33;
    #1;
    chk("clr_arb_ready0", 32'(bus.rq0_ready_o), 1);
    tick();
    bus.clear_req_i = 1'b0;
    bus.rq0_addr_i  = 5'd7;
    bus.rq0_data_i  = 32'h77;
    #1;
    chk("clr_pre_waddr", 32'(bus.rf_waddr_o), 3);
    chk("clr_pre_busy", 32'(bus.clear_busy_o), 1);
    chk("clr_pre_ready0", 32'(bus.rq0_ready_o), 0);
    nwr = 0;
    ndone = 0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (bus.rf_we_o && bus.rf_wdata_o == 0) nwr++;
      chk("clr_we", 32'(bus.rf_we_o), 1);
      chk("clr_waddr", 32'(bus.rf_waddr_o), k);
      chk("clr_wdata", bus.rf_wdata_o, 0);
      chk("clr_busy", 32'(bus.clear_busy_o), (k < 31) ? 1 : 0);
      chk("clr_done", 32'(bus.clear_done_o), (k < 31) ? 0 : 1);
      chk("clr_ready0", 32'(bus.rq0_ready_o), (k < 31) ? 0 : 1);
    end
    chk("clr_nwr", 32'(nwr), 31);
    tick();
    bus.rq0_valid_i = 1'b0;
    chk("post_done", 32'(bus.clear_done_o), 0);
    chk("post_we", 32'(bus.rf_we_o), 1);
    chk("post_waddr", 32'(bus.rf_waddr_o), 7);
    chk("post_wdata", bus.rf_wdata_o, 32'h77);

    // reset in the middle of a clear
    bus.clear_req_i = 1'b1;
    tick();
    bus.clear_req_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_waddr", 32'(bus.rf_waddr_o), 10);
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_we", 32'(bus.rf_we_o), 0);
    chk("mid_rst_waddr", 32'(bus.rf_waddr_o), 0);
    chk("mid_rst_busy", 32'(bus.clear_busy_o), 0);
    chk("mid_rst_done", 32'(bus.clear_done_o), 0);
    rst_ni = 1'b1;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.clear_done_o) ndone++;
      chk("mid_after_busy", 32'(bus.clear_busy_o), 0);
    end
    chk("mid_no_done", 32'(ndone), 0);
    bus.rq1_valid_i = 1'b1;
    bus.rq1_addr_i  = 5'd4;
    #1;
    chk("mid_idle_ready1", 32'(bus.rq1_ready_o), 1);
    tick();
    idle_in();

    // clear re-triggered at address 20
    bus.clear_req_i = 1'b1;
    tick();
    bus.clear_req_i = 1'b0;
    nwr = 0;
    ndone = 0;
    lastw = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      bus.clear_req_i = 1'b0;
      if (bus.rf_we_o) begin
        nwr++;
        lastw = int'(bus.rf_waddr_o);
        if (bus.rf_waddr_o == 5'd20) bus.clear_req_i = 1'b1;
      end
      if (bus.clear_done_o) ndone++;
    end
    chk("retrig_nwr", 32'(nwr), 31);
    chk("retrig_ndone", 32'(ndone), 1);
    chk("retrig_last", 32'(lastw), 31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
